// File: rtl/noc_packetizer.sv
// noc_packetizer: local-port injection stage in front of one XY mesh node.
// It accepts one wide message per handshake and slices it into single-flit
// packets. Every flit carries the full XY routing header, so the mesh routes
// each flit on its own; deterministic XY routing keeps the flits in order.
module noc_packetizer #(
  parameter int DATA_WIDTH    = 32,
  parameter int X_DIMENSION   = 4,
  parameter int Y_DIMENSION   = 4,
  parameter int FLITS_PER_MSG = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [FLITS_PER_MSG*(DATA_WIDTH
               - ((X_DIMENSION > 1) ? $clog2(X_DIMENSION) : 1)
               - ((Y_DIMENSION > 1) ? $clog2(Y_DIMENSION) : 1)
               - $clog2(FLITS_PER_MSG) - 1)-1:0] msg_data_i,
  input  logic [((X_DIMENSION > 1) ? $clog2(X_DIMENSION) : 1)-1:0] msg_dest_x_i,
  input  logic [((Y_DIMENSION > 1) ? $clog2(Y_DIMENSION) : 1)-1:0] msg_dest_y_i,
  input  logic [$clog2(FLITS_PER_MSG)-1:0]     msg_len_i,
  input  logic                                 msg_valid_i,
  output logic                                 msg_ready_o,
  output logic [DATA_WIDTH-1:0]                flit_data_o,
  output logic                                 flit_valid_o,
  input  logic                                 flit_ready_i,
  output logic                                 err_o,
  output logic [15:0]                          msg_cnt_o
);

  // Header field widths; a one-column or one-row mesh still gets a 1-bit field.
  localparam int XW        = (X_DIMENSION > 1) ? $clog2(X_DIMENSION) : 1;
  localparam int YW        = (Y_DIMENSION > 1) ? $clog2(Y_DIMENSION) : 1;
  localparam int IW        = $clog2(FLITS_PER_MSG);
  localparam int PW        = DATA_WIDTH - XW - YW - IW - 1;
  localparam int MSG_WIDTH = FLITS_PER_MSG * PW;

  // Limits widened by one bit so the compare also works for power-of-two sizes.
  localparam logic [XW:0] X_LIM   = (XW+1)'(X_DIMENSION);
  localparam logic [YW:0] Y_LIM   = (YW+1)'(Y_DIMENSION);
  localparam logic [IW:0] LEN_LIM = (IW+1)'(FLITS_PER_MSG);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [MSG_WIDTH-1:0]   data_reg;
  logic [XW-1:0]          dest_x_reg;
  logic [YW-1:0]          dest_y_reg;
  logic [IW-1:0]          len_reg;
  logic [IW-1:0]          idx_reg;
  logic                   flit_valid_reg;
  logic                   err_reg;
  logic [15:0]            msg_cnt_reg;

  logic                   msg_legal;
  logic                   last_flit;
  logic                   flit_fire;
  logic [PW-1:0]          chunk [FLITS_PER_MSG];

  // A message is legal when the destination lies inside the mesh and its
  // length fits in the latched payload.
  assign msg_legal = ({1'b0, msg_dest_x_i} < X_LIM) &&
                     ({1'b0, msg_dest_y_i} < Y_LIM) &&
                     ({1'b0, msg_len_i}    < LEN_LIM);

  assign last_flit = (idx_reg == len_reg);
  assign flit_fire = flit_valid_reg && flit_ready_i;

  // Split the latched message into its per-flit payload chunks.
  generate
    for (genvar gi = 0; gi < FLITS_PER_MSG; gi++) begin : g_chunk
      assign chunk[gi] = data_reg[gi*PW +: PW];
    end
  endgenerate

  // The flit is built from registered state only, so it holds steady during
  // a stall. It is forced to zero while no flit is offered so the bus is
  // deterministic in idle and reset.
  always_comb begin
    flit_data_o = '0;
    if (flit_valid_reg) begin
      flit_data_o = {dest_x_reg, dest_y_reg, idx_reg, last_flit, chunk[idx_reg]};
    end
  end

  // Accept in IDLE, or on the cycle the last flit leaves, so that
  // back-to-back messages see no bubble.
  always_comb begin
    msg_ready_o = 1'b0;
    if (state_reg == IDLE) begin
      msg_ready_o = 1'b1;
    end else begin
      msg_ready_o = last_flit && flit_ready_i;
    end
  end

  assign flit_valid_o = flit_valid_reg;
  assign err_o        = err_reg;
  assign msg_cnt_o    = msg_cnt_reg;

  // Control FSM: message acceptance, flit sequencing, error pulse and counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      data_reg       <= '0;
      dest_x_reg     <= '0;
      dest_y_reg     <= '0;
      len_reg        <= '0;
      idx_reg        <= '0;
      flit_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      msg_cnt_reg    <= '0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (msg_valid_i) begin
            if (msg_legal) begin
              data_reg       <= msg_data_i;
              dest_x_reg     <= msg_dest_x_i;
              dest_y_reg     <= msg_dest_y_i;
              len_reg        <= msg_len_i;
              idx_reg        <= '0;
              flit_valid_reg <= 1'b1;
              state_reg      <= SEND;
            end else begin
              // Illegal messages are consumed and dropped with an error pulse.
              err_reg <= 1'b1;
            end
          end
        end
        SEND: begin
          if (flit_fire) begin
            if (!last_flit) begin
              idx_reg <= idx_reg + 1'b1;
            end else begin
              msg_cnt_reg <= msg_cnt_reg + 16'd1;
              if (msg_valid_i && msg_legal) begin
                // Next message rides straight in behind the last flit.
                data_reg   <= msg_data_i;
                dest_x_reg <= msg_dest_x_i;
                dest_y_reg <= msg_dest_y_i;
                len_reg    <= msg_len_i;
                idx_reg    <= '0;
              end else begin
                err_reg        <= msg_valid_i;
                flit_valid_reg <= 1'b0;
                state_reg      <= IDLE;
              end
            end
          end
        end
        default: begin
          flit_valid_reg <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer: directed checks of the message-to-flit packetizer.
// u_dut uses the default 4x4 mesh; u_dut3 uses a 3-column mesh so that an
// out-of-range column can be offered.
module tb_noc_packetizer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic [99:0]  m_data = '0;
  logic [1:0]   m_x = '0;
  logic [1:0]   m_y = '0;
  logic [1:0]   m_len = '0;
  logic         m_valid = 1'b0;
  logic         m_ready;
  logic [31:0]  f_data;
  logic         f_valid;
  logic         f_ready = 1'b1;
  logic         m_err;
  logic [15:0]  m_cnt;

  logic [99:0]  n_data = '0;
  logic [1:0]   n_x = '0;
  logic [1:0]   n_y = '0;
  logic [1:0]   n_len = '0;
  logic         n_valid = 1'b0;
  logic         n_ready;
  logic [31:0]  n_fdata;
  logic         n_fvalid;
  logic         n_fready = 1'b1;
  logic         n_err;
  logic [15:0]  n_cnt;

  int           n_checks = 0;
  int           n_fails  = 0;

  always #5 clk = ~clk;

  noc_packetizer u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .msg_data_i   (m_data),
    .msg_dest_x_i (m_x),
    .msg_dest_y_i (m_y),
    .msg_len_i    (m_len),
    .msg_valid_i  (m_valid),
    .msg_ready_o  (m_ready),
    .flit_data_o  (f_data),
    .flit_valid_o (f_valid),
    .flit_ready_i (f_ready),
    .err_o        (m_err),
    .msg_cnt_o    (m_cnt)
  );

  noc_packetizer #(.X_DIMENSION(3)) u_dut3 (
    .clk_i        (clk),
    .rst_i        (rst),
    .msg_data_i   (n_data),
    .msg_dest_x_i (n_x),
    .msg_dest_y_i (n_y),
    .msg_len_i    (n_len),
    .msg_valid_i  (n_valid),
    .msg_ready_o  (n_ready),
    .flit_data_o  (n_fdata),
    .flit_valid_o (n_fvalid),
    .flit_ready_i (n_fready),
    .err_o        (n_err),
    .msg_cnt_o    (n_cnt)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [99:0] pack4(input logic [24:0] c0, input logic [24:0] c1,
                                        input logic [24:0] c2, input logic [24:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  logic [31:0] bp_exp [3];

  initial begin
    bp_exp[0] = 32'h90000005;   // x=2 y=1 idx0
    bp_exp[1] = 32'h94000006;   // idx1
    bp_exp[2] = 32'h9A000007;   // idx2 last

    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("rst_valid", {31'd0, f_valid}, 32'd0);
    check_eq("rst_err",   {31'd0, m_err},   32'd0);
    check_eq("rst_cnt",   {16'd0, m_cnt},   32'd0);
    check_eq("rst_ready", {31'd0, m_ready}, 32'd1);
    check_eq("rst_data",  f_data,           32'd0);
    tick();

    // Three-flit message to (3,1)
    m_data = pack4(25'h1, 25'h2, 25'h3, 25'h0);
    m_x = 2'd3; m_y = 2'd1; m_len = 2'd2; m_valid = 1'b1; f_ready = 1'b1;
    tick();
    m_valid = 1'b0;
    check_eq("t1_f0", f_data, 32'hD0000001);
    check_eq("t1_v0", {31'd0, f_valid}, 32'd1);
    tick();
    check_eq("t1_f1", f_data, 32'hD4000002);
    tick();
    check_eq("t1_f2", f_data, 32'hDA000003);
    check_eq("t1_rdy_last", {31'd0, m_ready}, 32'd1);
    tick();
    check_eq("t1_idle", {31'd0, f_valid}, 32'd0);
    check_eq("t1_cnt", {16'd0, m_cnt}, 32'd1);

    // Single-flit message to (0,2)
    m_data = pack4(25'h0ABCDEF, 25'h0, 25'h0, 25'h0);
    m_x = 2'd0; m_y = 2'd2; m_len = 2'd0; m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    check_eq("t2_f0", f_data, 32'h22ABCDEF);
    check_eq("t2_rdy", {31'd0, m_ready}, 32'd1);
    tick();
    check_eq("t2_idle", {31'd0, f_valid}, 32'd0);
    check_eq("t2_rdy_again", {31'd0, m_ready}, 32'd1);
    check_eq("t2_cnt", {16'd0, m_cnt}, 32'd2);

    // Back-to-back two-flit messages, no bubble
    m_data = pack4(25'h11, 25'h22, 25'h0, 25'h0);
    m_x = 2'd1; m_y = 2'd2; m_len = 2'd1; m_valid = 1'b1;
    tick();
    m_data = pack4(25'h33, 25'h44, 25'h0, 25'h0);
    m_x = 2'd2; m_y = 2'd3;
    #1;
    check_eq("t3_a0", f_data, 32'h60000011);
    check_eq("t3_rdy_mid", {31'd0, m_ready}, 32'd0);
    tick();
    check_eq("t3_a1", f_data, 32'h66000022);
    check_eq("t3_rdy_last", {31'd0, m_ready}, 32'd1);
    tick();
    m_valid = 1'b0;
    check_eq("t3_b0", f_data, 32'hB0000033);
    check_eq("t3_b0_v", {31'd0, f_valid}, 32'd1);
    tick();
    check_eq("t3_b1", f_data, 32'hB6000044);
    tick();
    check_eq("t3_idle", {31'd0, f_valid}, 32'd0);
    check_eq("t3_cnt", {16'd0, m_cnt}, 32'd4);

    // Backpressure: ready pattern 0,0,1 per flit
    m_data = pack4(25'h5, 25'h6, 25'h7, 25'h0);
    m_x = 2'd2; m_y = 2'd1; m_len = 2'd2; m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 3; s++) begin
        f_ready = (s == 2);
        #1;
        check_eq($sformatf("t4_f%0d_s%0d", k, s), f_data, bp_exp[k]);
        check_eq($sformatf("t4_v%0d_s%0d", k, s), {31'd0, f_valid}, 32'd1);
        tick();
      end
    end
    f_ready = 1'b1;
    check_eq("t4_idle", {31'd0, f_valid}, 32'd0);
    check_eq("t4_cnt", {16'd0, m_cnt}, 32'd5);

    // Illegal column on the 3-column mesh
    n_data = pack4(25'h1, 25'h2, 25'h0, 25'h0);
    n_x = 2'd3; n_y = 2'd0; n_len = 2'd1; n_valid = 1'b1;
    #1;
    check_eq("t5_rdy", {31'd0, n_ready}, 32'd1);
    tick();
    n_valid = 1'b0;
    check_eq("t5_err", {31'd0, n_err}, 32'd1);
    check_eq("t5_novalid", {31'd0, n_fvalid}, 32'd0);
    tick();
    check_eq("t5_err_gone", {31'd0, n_err}, 32'd0);
    check_eq("t5_novalid2", {31'd0, n_fvalid}, 32'd0);
    check_eq("t5_cnt", {16'd0, n_cnt}, 32'd0);

    // Legal single flit, illegal message offered on its last-flit cycle
    n_x = 2'd2; n_y = 2'd0; n_len = 2'd0; n_valid = 1'b1;
    tick();
    n_x = 2'd3;
    #1;
    check_eq("t5b_f0", n_fdata, 32'h82000001);
    tick();
    n_valid = 1'b0;
    check_eq("t5b_err", {31'd0, n_err}, 32'd1);
    check_eq("t5b_idle", {31'd0, n_fvalid}, 32'd0);
    check_eq("t5b_cnt", {16'd0, n_cnt}, 32'd1);
    tick();

    // Reset during flit idx1 of a four-flit message
    m_data = pack4(25'h8, 25'h9, 25'hA, 25'hB);
    m_x = 2'd1; m_y = 2'd1; m_len = 2'd3; m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    check_eq("t6_f0", f_data, 32'h50000008);
    tick();
    check_eq("t6_f1", f_data, 32'h54000009);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_rst_valid", {31'd0, f_valid}, 32'd0);
    check_eq("t6_rst_cnt", {16'd0, m_cnt}, 32'd0);
    m_data = pack4(25'hC, 25'hD, 25'h0, 25'h0);
    m_x = 2'd3; m_y = 2'd3; m_len = 2'd1; m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    check_eq("t6_new_f0", f_data, 32'hF000000C);
    tick();
    check_eq("t6_new_f1", f_data, 32'hF600000D);
    tick();
    check_eq("t6_new_cnt", {16'd0, m_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
